reg_file_sb: RTL
================

// Module: reg_file_sb
// PURPOSE
// - Pipeline register file: array of 2^ADDR_W rows x DATA_W bit cells, one write port, two read ports.
// - Per-register busy scoreboard set at issue, cleared at write-back; flags RAW hazards to the decode stage.
// - Sits between decode (read/issue) and write-back (write/clear). Each storage bit is one bit-cell equivalent.
// PARAMETERS
// - DATA_W  16  register width in bits
// - ADDR_W  4   register index width; register count NREG = 2**ADDR_W
// PORTS
// - clk         in   1       clock; all state updates on posedge
// - rst         in   1       reset, asynchronous, active-high; clears all state
// - wb_en       in   1       write-back enable; writes wb_data and clears busy[wb_reg]
// - wb_reg      in   ADDR_W  write-back destination index
// - wb_data     in   DATA_W  write-back value
// - rd1_en      in   1       read-port 1 enable
// - rd1_reg     in   ADDR_W  read-port 1 index
// - rd1_data    out  DATA_W  read-port 1 value
// - rd2_en      in   1       read-port 2 enable
// - rd2_reg     in   ADDR_W  read-port 2 index
// - rd2_data    out  DATA_W  read-port 2 value
// - issue_en    in   1       issue of instruction with destination; sets busy[issue_reg]
// - issue_reg   in   ADDR_W  destination index of issued instruction
// - hazard      out  1       RAW stall request to decode
// - busy_vec    out  NREG    current scoreboard bits, bit i = register i
// BEHAVIOUR
// - Reset (async, rst=1): every register = 0, busy_vec = 0. Outputs while rst=1: rd1_data = rd2_data = 0, hazard = 0.
// - Reset mid-operation: pending writes and issues in that cycle are discarded; all state restarts from zero.
// - Register 0: reads always 0; writes to index 0 ignored; busy[0] never set; never causes hazard.
// - Write: on posedge with wb_en=1 and wb_reg!=0: reg[wb_reg] <= wb_data. One-cycle latency (visible at
//   next cycle's reads) unless bypass compiled in.
// - Read: combinational. rdN_en=0 -> rdN_data = 0 (bitline not driven, read as 0). rdN_en=1 -> reg[rdN_reg].
// - Both read ports may address the same register in the same cycle; both return the same value.
// - Scoreboard, per posedge, index i != 0:
//   - issue_en & issue_reg==i -> busy[i] <= 1
//   - else wb_en & wb_reg==i -> busy[i] <= 0
//   - else hold. Simultaneous issue and write-back to the same index: set wins (newer producer).
//   - Issue to an already-busy register: stays busy; the first write-back clears it (single outstanding
//     writer per register is the issuer's responsibility).
// - hazard (combinational) = (rd1_en & busy[rd1_reg] & ~fwd1) | (rd2_en & busy[rd2_reg] & ~fwd2),
//   where fwdN = bypass match (below) when RF_BYPASS_EN is defined, else 0.
// - No wrap-around or overflow state; indices are full-range and always valid.
// CONFIGURATION
// - RF_BYPASS_EN defined: rdN_en & wb_en & wb_reg==rdN_reg & rdN_reg!=0 -> rdN_data = wb_data in the same
//   cycle (write-before-read); that port is exempt from hazard through busy[rdN_reg].
// - RF_BYPASS_EN undefined: reads return array contents only; a same-cycle write-back to a busy source
//   still asserts hazard for that cycle; the value is visible the next cycle.
// TESTING
// - Reset: rst=1 mid-run after writes to R3/R7 -> all reads 0, busy_vec=0, hazard=0; rst=0 -> reads still 0.
// - Write/read: wb R5=16'hA5A5, next cycle rd1_reg=5, rd2_reg=5, both enabled -> both 16'hA5A5;
//   rd1_en=0 -> rd1_data=0.
// - R0: wb R0=16'hFFFF; issue_reg=0 -> rd1(R0)=0, busy_vec[0]=0, hazard=0.
// - Scoreboard: issue R4 -> busy_vec=16'h0010; rd2 R4 -> hazard=1; wb R4=16'h1234 -> busy clear next
//   cycle, hazard=0, rd2=16'h1234.
// - Collision: issue R6 and wb R6 in the same cycle -> busy_vec[6]=1 afterwards, reg[6] updated.
// - Bypass: R2 busy, wb R2=16'h0F0F with rd1 R2 same cycle -> with RF_BYPASS_EN rd1=16'h0F0F, hazard=0;
//   without -> rd1=old value, hazard=1.

Source files
------------

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - pipeline register file with busy scoreboard and RAW hazard flag
//
// Purpose: 2**ADDR_W x DATA_W register file, one write-back port, two combinational
// read ports, per-register busy bits set at issue and cleared at write-back.
// Optional build macro: RF_BYPASS_EN (same-cycle write-back to read forwarding).
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   wb_en/wb_reg/wb_data      write-back: writes register, clears busy bit
//   rd1_en/rd1_reg/rd1_data   read port 1 (data is 0 when disabled)
//   rd2_en/rd2_reg/rd2_data   read port 2 (data is 0 when disabled)
//   issue_en/issue_reg        issue of a producer: sets busy bit
//   hazard                    RAW stall request to decode
//   busy_vec                  scoreboard bits, bit i = register i

module reg_file_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_en,
    input  logic [ADDR_W-1:0]      wb_reg,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic                   rd1_en,
    input  logic [ADDR_W-1:0]      rd1_reg,
    output logic [DATA_W-1:0]      rd1_data,
    input  logic                   rd2_en,
    input  logic [ADDR_W-1:0]      rd2_reg,
    output logic [DATA_W-1:0]      rd2_data,
    input  logic                   issue_en,
    input  logic [ADDR_W-1:0]      issue_reg,
    output logic                   hazard,
    output logic [(1<<ADDR_W)-1:0] busy_vec
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic              fwd1;
    logic              fwd2;

    // Register 0 is never written and its busy bit never set, so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wb_en && (wb_reg != '0)) begin
                regs[wb_reg] <= wb_data;
            end
            busy[0] <= 1'b0;
            for (int i = 1; i < NREG; i++) begin
                // Issue wins over a same-cycle write-back: the issued producer is newer.
                if (issue_en && (issue_reg == ADDR_W'(i))) begin
                    busy[i] <= 1'b1;
                end else if (wb_en && (wb_reg == ADDR_W'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

`ifdef RF_BYPASS_EN
    assign fwd1 = rd1_en && wb_en && (wb_reg == rd1_reg) && (rd1_reg != '0);
    assign fwd2 = rd2_en && wb_en && (wb_reg == rd2_reg) && (rd2_reg != '0);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    // Outputs are forced quiet while reset is held, including any forwarded value.
    always_comb begin
        rd1_data = '0;
        rd2_data = '0;
        if (!rst && rd1_en && (rd1_reg != '0)) begin
            rd1_data = fwd1 ? wb_data : regs[rd1_reg];
        end
        if (!rst && rd2_en && (rd2_reg != '0)) begin
            rd2_data = fwd2 ? wb_data : regs[rd2_reg];
        end
    end

    assign hazard   = !rst && ((rd1_en && busy[rd1_reg] && !fwd1) ||
                               (rd2_en && busy[rd2_reg] && !fwd2));
    assign busy_vec = busy;

endmodule
